// File: rtl/mcpu_ram_controller.sv
// mcpu_ram_controller: unified MCPU memory with one read/write data port and
// one read-only instruction-fetch port. Writes are synchronous. Both reads are
// combinational. An asynchronous reset clears the whole array.
//
// Port semantics:
// - Data writes happen only on a rising clk edge with we=1 and rst=0.
// - datard shows mem[addr] when re=1 and 0 when re=0.
// - instrrd always shows mem[instraddr] and has no enable.
// - Nothing forwards a pending write to either read port. Reads show the
//   old word until the edge and the new word right after it.
module mcpu_ram_controller #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_SIZE   = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [WORD_SIZE-1:0]  datawr,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [WORD_SIZE-1:0]  datard,
  input  logic [ADDR_WIDTH-1:0] instraddr,
  output logic [WORD_SIZE-1:0]  instrrd
);

  logic [WORD_SIZE-1:0] mem [RAM_SIZE];

  // Storage: reset clears every word at once and blocks writes while held.
  // Otherwise a write enable commits one word per edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAM_SIZE; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= datawr;
    end
  end

  // Data read port: combinational and forced to zero when not enabled.
  always_comb begin
    datard = '0;
    if (re) begin
      datard = mem[addr];
    end
  end

  // Instruction-fetch port: combinational and always enabled.
  always_comb begin
    instrrd = mem[instraddr];
  end

endmodule

// File: tb/tb_mcpu_ram_controller.sv
// Testbench for mcpu_ram_controller. Directed vectors drive the RAM, and the
// expected {datard, instrrd} pair for each observation is queued. A separate
// monitor pops each pair and compares it when a sample strobe fires.
module tb_mcpu_ram_controller;

  localparam int W  = 8;
  localparam int AW = 8;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [W-1:0]  datawr = '0;
  logic [AW-1:0] addr = '0;
  logic [AW-1:0] instraddr = '0;
  logic [W-1:0]  datard;
  logic [W-1:0]  instrrd;

  mcpu_ram_controller #(.WORD_SIZE(W), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .datawr    (datawr),
    .re        (re),
    .addr      (addr),
    .datard    (datard),
    .instraddr (instraddr),
    .instrrd   (instrrd)
  );

  // Scoreboard
  logic [2*W-1:0] exp_q[$];
  string          name_q[$];
  int             passed = 0;
  int             total  = 0;
  logic           chk_stb = 1'b0;
  logic [W-1:0]   model [256];

  // Monitor: each strobe pops one expectation and compares it with the outputs.
  always @(posedge chk_stb) begin
    logic [2*W-1:0] e;
    string          n;
    total++;
    if (exp_q.size() == 0) begin
      $display("FAIL monitor: strobe with empty queue, datard=%h instrrd=%h", datard, instrrd);
    end else begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if ({datard, instrrd} !== e) begin
        $display("FAIL %s: addr=%h instraddr=%h re=%b got datard=%h instrrd=%h, want datard=%h instrrd=%h",
                 n, addr, instraddr, re, datard, instrrd, e[2*W-1:W], e[W-1:0]);
      end else begin
        passed++;
      end
    end
  end

  // Driver tasks
  task automatic expect_out(input string n, input logic [W-1:0] d, input logic [W-1:0] i);
    exp_q.push_back({d, i});
    name_q.push_back(n);
    chk_stb = 1'b1;
    #1;
    chk_stb = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    we = 1'b1;
    addr = a;
    datawr = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic look(input string n, input logic [AW-1:0] a, input logic [AW-1:0] ia,
                      input logic r, input logic [W-1:0] d, input logic [W-1:0] i);
    @(negedge clk);
    addr = a;
    instraddr = ia;
    re = r;
    #2;
    expect_out(n, d, i);
  endtask

  initial begin
    // Reset clear
    #12;
    rst = 1'b1;
    re = 1'b1;
    #1;
    expect_out("reset_held", 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 256; a++) begin
      look("reset_sweep", AW'(a), AW'(a), 1'b1, 8'h00, 8'h00);
    end

    // Fill and dual readback
    re = 1'b0;
    for (int a = 0; a < 256; a++) begin
      model[a] = W'($urandom_range(0, 255));
    end
    model[8'h3C] = 8'hA5;
    for (int a = 0; a < 256; a++) begin
      do_write(AW'(a), model[a]);
    end
    for (int a = 0; a < 256; a++) begin
      look("fill_readback", AW'(a), AW'(a), 1'b1, model[a], model[a]);
    end
    look("fill_3c", 8'h3C, 8'h3C, 1'b1, 8'hA5, 8'hA5);

    // Independent ports
    do_write(8'h10, 8'h11);
    do_write(8'hF0, 8'h22);
    look("indep_both", 8'h10, 8'hF0, 1'b1, 8'h11, 8'h22);
    look("indep_re0", 8'h10, 8'hF0, 1'b0, 8'h00, 8'h22);

    // Read-during-write: old value before the edge, new value after it
    do_write(8'h05, 8'h33);
    @(negedge clk);
    we = 1'b1;
    re = 1'b1;
    addr = 8'h05;
    instraddr = 8'h05;
    datawr = 8'hCC;
    #2;
    expect_out("rdw_before", 8'h33, 8'h33);
    @(posedge clk);
    #1;
    expect_out("rdw_after", 8'hCC, 8'hCC);
    we = 1'b0;

    // Back-to-back writes on successive edges, last write wins
    @(negedge clk);
    we = 1'b1; addr = 8'h40; datawr = 8'h12;
    @(negedge clk);
    addr = 8'h40; datawr = 8'h34;
    @(negedge clk);
    addr = 8'h41; datawr = 8'h56;
    @(negedge clk);
    we = 1'b0;
    look("b2b_same", 8'h40, 8'h41, 1'b1, 8'h34, 8'h56);

    // Reset mid-operation, asserted between edges
    @(negedge clk);
    addr = 8'h10;
    instraddr = 8'hF0;
    re = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    expect_out("midrst_immediate", 8'h00, 8'h00);
    @(negedge clk);
    we = 1'b1;
    addr = 8'h80;
    datawr = 8'h77;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    rst = 1'b0;
    look("midrst_lost_write", 8'h80, 8'h80, 1'b1, 8'h00, 8'h00);
    look("midrst_old_cleared", 8'h10, 8'hF0, 1'b1, 8'h00, 8'h00);
    do_write(8'h80, 8'h77);
    look("midrst_write_after", 8'h80, 8'h80, 1'b1, 8'h77, 8'h77);

    // Corner addresses with no aliasing
    do_write(8'h00, 8'hFF);
    do_write(8'hFF, 8'h01);
    look("corner_a", 8'h00, 8'hFF, 1'b1, 8'hFF, 8'h01);
    look("corner_b", 8'hFF, 8'h00, 1'b1, 8'h01, 8'hFF);
    look("corner_re0", 8'h00, 8'h00, 1'b0, 8'h00, 8'hFF);

    // Final report once the monitor has drained the queue (bounded wait)
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left in queue, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
